// File: rtl/counter_act_param.sv
// Parametrised modulo up/down counter with load, terminal-count pulse and a
// saturating accumulator of output bit toggles for power-flow cross-checking.
module counter_act_param #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16,
    parameter int ACT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_act,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic [ACT_W-1:0] activity,
    output logic             act_sat
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
    localparam int TOG_W = $clog2(WIDTH + 1);
    // Wide enough for activity + toggles even when WIDTH exceeds the accumulator range
    localparam int SUM_W = ((TOG_W > ACT_W) ? TOG_W : ACT_W) + 1;

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic [ACT_W-1:0] activity_q, activity_d;
    logic             act_sat_q, act_sat_d;

    logic [WIDTH-1:0] diff;
    logic [TOG_W-1:0] toggles;
    logic [SUM_W-1:0] base;
    logic [SUM_W-1:0] sum;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_CNT) ? MAX_CNT : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (count_q == MAX_CNT) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MAX_CNT;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_comb begin
        diff    = count_q ^ count_d;
        toggles = '0;
        for (int i = 0; i < WIDTH; i++) begin
            toggles = toggles + TOG_W'(diff[i]);
        end
    end

    // Clear-then-add: a clear on the same edge still books this edge's toggles
    always_comb begin
        base       = clr_act ? '0 : SUM_W'(activity_q);
        sum        = base + SUM_W'(toggles);
        activity_d = sum[ACT_W-1:0];
        act_sat_d  = clr_act ? 1'b0 : act_sat_q;
        if (sum > SUM_W'({ACT_W{1'b1}})) begin
            activity_d = '1;
            act_sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            tc_q       <= 1'b0;
            activity_q <= '0;
            act_sat_q  <= 1'b0;
        end else begin
            count_q    <= count_d;
            tc_q       <= tc_d;
            activity_q <= activity_d;
            act_sat_q  <= act_sat_d;
        end
    end

    assign count    = count_q;
    assign tc       = tc_q;
    assign activity = activity_q;
    assign act_sat  = act_sat_q;

endmodule

// File: tb/tb_counter_act_param.sv
// Directed bench for counter_act_param: three instances (default, MODULUS=10,
// ACT_W=4) share one stimulus stream; each table row names the instance it checks.
module tb_counter_act_param;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic       clr_act;

    logic [3:0]  count_def, count_m10, count_a4;
    logic        tc_def, tc_m10, tc_a4;
    logic [15:0] act_def, act_m10;
    logic [3:0]  act_a4;
    logic        sat_def, sat_m10, sat_a4;

    int testsRun;
    int testsFailed;

    counter_act_param #(.WIDTH(4), .MODULUS(16), .ACT_W(16)) u_def (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clr_act(clr_act),
        .count(count_def), .tc(tc_def), .activity(act_def), .act_sat(sat_def)
    );

    counter_act_param #(.WIDTH(4), .MODULUS(10), .ACT_W(16)) u_m10 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clr_act(clr_act),
        .count(count_m10), .tc(tc_m10), .activity(act_m10), .act_sat(sat_m10)
    );

    counter_act_param #(.WIDTH(4), .MODULUS(16), .ACT_W(4)) u_a4 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clr_act(clr_act),
        .count(count_a4), .tc(tc_a4), .activity(act_a4), .act_sat(sat_a4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        up_dn;
        logic        load;
        logic [3:0]  load_val;
        logic        clr_act;
        int          sel;
        logic [3:0]  exp_count;
        logic        exp_tc;
        logic [15:0] exp_act;
        logic        exp_sat;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic r, input logic e, input logic u, input logic l,
                          input logic [3:0] lv, input logic c, input int s,
                          input logic [3:0] ec, input logic et, input logic [15:0] ea,
                          input logic es);
        vec_t v;
        v.rst = r; v.en = e; v.up_dn = u; v.load = l; v.load_val = lv; v.clr_act = c;
        v.sel = s; v.exp_count = ec; v.exp_tc = et; v.exp_act = ea; v.exp_sat = es;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic u,
                                 input logic l, input logic [3:0] lv, input logic c);
        rst      = r;
        en       = e;
        up_dn    = u;
        load     = l;
        load_val = lv;
        clr_act  = c;
    endtask

    task automatic checkOutput(input string name, input int sel, input logic [3:0] ec,
                               input logic et, input logic [15:0] ea, input logic es);
        logic [3:0]  c;
        logic        t;
        logic [15:0] a;
        logic        s;
        case (sel)
            1:       begin c = count_m10; t = tc_m10; a = act_m10;         s = sat_m10; end
            2:       begin c = count_a4;  t = tc_a4;  a = {12'b0, act_a4}; s = sat_a4;  end
            default: begin c = count_def; t = tc_def; a = act_def;         s = sat_def; end
        endcase
        testsRun++;
        if (c !== ec) begin
            testsFailed++;
            $display("[TB] FAIL %s count: got %0d expected %0d", name, c, ec);
        end
        testsRun++;
        if (t !== et) begin
            testsFailed++;
            $display("[TB] FAIL %s tc: got %0b expected %0b", name, t, et);
        end
        testsRun++;
        if (a !== ea) begin
            testsFailed++;
            $display("[TB] FAIL %s activity: got %0d expected %0d", name, a, ea);
        end
        testsRun++;
        if (s !== es) begin
            testsFailed++;
            $display("[TB] FAIL %s act_sat: got %0b expected %0b", name, s, es);
        end
    endtask

    int cum[16] = '{1, 3, 4, 7, 8, 10, 11, 15, 16, 18, 19, 22, 23, 25, 26, 30};

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Default instance: one full up-count period
        addVec(0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 16'd0, 0);
        for (int i = 1; i <= 16; i++)
            addVec(1, 1, 1, 0, 0, 0, 0, 4'(i % 16), (i == 16), 16'(cum[i-1]), 0);

        // ACT_W=4 instance: saturation, then clear-then-add
        addVec(0, 0, 0, 0, 0, 0, 2, 4'd0, 0, 16'd0, 0);
        for (int i = 1; i <= 8; i++)
            addVec(1, 1, 1, 0, 0, 0, 2, 4'(i), 0, 16'(cum[i-1]), 0);
        addVec(1, 1, 1, 0, 0, 0, 2, 4'd9,  0, 16'd15, 1);
        addVec(1, 1, 1, 0, 0, 1, 2, 4'd10, 0, 16'd2,  0);
        addVec(1, 1, 1, 0, 0, 0, 2, 4'd11, 0, 16'd3,  0);

        // MODULUS=10 instance: wraps, direction change, load clamp, hold
        addVec(0, 0, 0, 0, 0,     0, 1, 4'd0, 0, 16'd0,  0);
        addVec(1, 1, 1, 1, 4'd8,  0, 1, 4'd8, 0, 16'd1,  0);
        addVec(1, 1, 1, 0, 0,     0, 1, 4'd9, 0, 16'd2,  0);
        addVec(1, 1, 1, 0, 0,     0, 1, 4'd0, 1, 16'd4,  0);
        addVec(1, 1, 0, 0, 0,     0, 1, 4'd9, 1, 16'd6,  0);
        addVec(1, 1, 0, 0, 0,     0, 1, 4'd8, 0, 16'd7,  0);
        addVec(1, 1, 1, 1, 4'd7,  0, 1, 4'd7, 0, 16'd11, 0);
        addVec(1, 1, 1, 1, 4'd12, 0, 1, 4'd9, 0, 16'd14, 0);
        addVec(1, 1, 1, 1, 4'd9,  0, 1, 4'd9, 0, 16'd14, 0);
        addVec(1, 1, 1, 0, 0,     0, 1, 4'd0, 1, 16'd16, 0);
        addVec(1, 0, 1, 1, 4'd6,  0, 1, 4'd6, 0, 16'd18, 0);
        for (int i = 0; i < 5; i++)
            addVec(1, 0, 1'(i % 2), 0, 0, 0, 1, 4'd6, 0, 16'd18, 0);
        addVec(1, 1, 0, 1, 4'd3,  1, 1, 4'd3, 0, 16'd2,  0);

        // Default instance: park at 11 ahead of the asynchronous reset sequence
        addVec(0, 0, 0, 0, 0,     0, 0, 4'd0,  0, 16'd0, 0);
        addVec(1, 1, 1, 1, 4'd11, 0, 0, 4'd11, 0, 16'd3, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].up_dn, vecs[i].load,
                          vecs[i].load_val, vecs[i].clr_act);
            @(posedge clk);
            #1;
            checkOutput($sformatf("row%0d", i), vecs[i].sel, vecs[i].exp_count,
                        vecs[i].exp_tc, vecs[i].exp_act, vecs[i].exp_sat);
        end

        // Reset dropped between edges must clear outputs without a clock edge
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        #1;
        checkOutput("async_rst_immediate", 0, 4'd0, 0, 16'd0, 0);
        @(posedge clk);
        #1;
        checkOutput("async_rst_held", 0, 4'd0, 0, 16'd0, 0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("after_release", 0, 4'd1, 0, 16'd1, 0);
        @(posedge clk);
        #1;
        checkOutput("after_release2", 0, 4'd2, 0, 16'd3, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
